multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Multicycle control FSM for the RV32I core. It sequences fetch, decode, execute, memory and writeback for the supported subset: addi, beq/bne, lw/lb/lbu, sw/sb, jal, jalr.
- Drives ImmSrc to the immediate sign-extender, plus ALU operand selects, ALU op, register-file write, IR/PC enables and a req/ready memory handshake.
- Sits between the instruction register and the shared datapath: one ALU, one memory port.

Parameters:
- D_WIDTH, 32, instruction/datapath width; only 32 supported.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr  in  32  current instruction register contents
- zero  in  1  ALU zero flag, valid in BRANCH state
- mem_ready  in  1  memory completes the access in this cycle
- mem_req  out  1  memory access request, held until mem_ready
- mem_we  out  1  request is a write
- adr_src  out  1  0 = PC, 1 = ALUOut as memory address
- ir_write  out  1  load instr register
- pc_write  out  1  load PC from result bus
- reg_write  out  1  register-file write enable
- ImmSrc  out  2  0 = no immediate, 1 = sign-extend per opcode
- alu_src_a  out  2  0 = PC, 1 = oldPC, 2 = rs1
- alu_src_b  out  2  0 = rs2, 1 = ImmExt, 2 = constant 4
- alu_ctrl  out  3  000 = ADD, 001 = SUB
- result_src  out  2  0 = ALUOut, 1 = mem data, 2 = ALU result
- instr_done  out  1  one-cycle pulse on retire
- illegal  out  1  sticky; unsupported opcode/funct3 decoded

Behaviour:
- Reset (rst_n low, async):
  - State goes to FETCH; illegal clears.
  - All outputs are 0 except mem_req = 1 once rst_n deasserts.
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECI, ALUWB, BRANCH, JAL, JALR, TRAP. Outputs are Moore unless noted.
- FETCH:
  - mem_req = 1, adr_src = 0, alu_src_a = 0, alu_src_b = 2, ADD, result_src = 2.
  - Mealy: ir_write = pc_write = mem_ready.
  - Stays in FETCH while mem_ready = 0. On mem_ready = 1, goes to DECODE.
- DECODE:
  - alu_src_a = 1, alu_src_b = 1, ImmSrc = 1, ADD. This precomputes the branch target into ALUOut.
  - Next state by opcode:
    - 3 or 35 -> MEMADR
    - 19 -> EXECI
    - 99 -> BRANCH
    - 111 -> JAL
    - 103 -> JALR
    - anything else -> TRAP
  - funct3 legality: addi 000; branch 000/001; load 000/010/100; store 000/010; jalr 000. An illegal funct3 -> TRAP.
- MEMADR:
  - alu_src_a = 2, alu_src_b = 1, ImmSrc = 1, ADD.
  - Load -> MEMREAD; store -> MEMWRITE.
- MEMREAD: mem_req = 1, adr_src = 1. Wait for mem_ready, then -> MEMWB.
- MEMWB: result_src = 1, reg_write = 1, instr_done = 1 -> FETCH.
- MEMWRITE: mem_req = 1, mem_we = 1, adr_src = 1. On mem_ready: instr_done = 1 (Mealy) -> FETCH.
- EXECI: alu_src_a = 2, alu_src_b = 1, ImmSrc = 1, ADD -> ALUWB.
- ALUWB: result_src = 0, reg_write = 1, instr_done = 1 -> FETCH.
- BRANCH:
  - alu_src_a = 2, alu_src_b = 0, SUB, result_src = 0.
  - Mealy: pc_write = (funct3 == 000 & zero) | (funct3 == 001 & ~zero).
  - instr_done = 1 -> FETCH.
- JAL:
  - pc_write = 1 with result_src = 0 (ALUOut = oldPC + imm).
  - alu_src_a = 1, alu_src_b = 2, ADD (link = oldPC + 4) -> ALUWB.
- JALR: two cycles via internal substate.
  - Cycle 1: rs1 + imm into ALUOut.
  - Cycle 2: pc_write with result_src = 0, ALU computes oldPC + 4 -> ALUWB.
- TRAP: illegal = 1, all enables 0, no exit except reset.
- mem_req stays high and address/mem_we stay stable while waiting; mem_ready outside a request state is ignored.
- Retire latency with mem_ready immediate:
  - branch 3 cycles
  - addi 4
  - store 4
  - jal 4
  - load 5
  - jalr 5
  - Each mem_ready wait cycle adds 1.
- Reset asserted mid-instruction aborts immediately. No partial reg_write/pc_write is produced after rst_n falls.

Decomposition:
- Package mc_pkg: state enum, opcode constants (19, 99, 3, 35, 103, 111), alu_ctrl codes, src-select encodings, ImmSrc codes.
- Sub-module mc_instr_class: combinational opcode/funct3 -> class {LOAD, STORE, ALUI, BRANCH, JAL, JALR, ILLEGAL}. The FSM consumes only the class plus funct3[0].

Test Plan:
- Reset held 3 cycles, then released, mem_ready = 1 -> FETCH; ir_write = pc_write = 1 on first cycle; illegal = 0.
- addi x1,x0,5 (0x00500093), mem_ready tied 1 -> ImmSrc = 1 in DECODE/EXECI; reg_write in cycle 4; instr_done pulses once.
- lw x2,4(x0) (0x00402103), mem_ready low 2 cycles in MEMREAD -> mem_req/adr_src = 1 held; reg_write with result_src = 1 at cycle 7.
- beq (0x00000463) with zero = 1 -> pc_write in BRANCH, result_src = 0. bne (0x00001463) with zero = 1 -> no pc_write. Both retire in 3 cycles.
- Opcode 0x33 (0x002081B3) -> TRAP after DECODE; illegal stays 1 and no enables fire for 20 cycles.
- rst_n dropped while in MEMWRITE awaiting mem_ready -> all outputs 0 that cycle; restart in FETCH; no mem_we after release until a new store.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the RV32I multicycle control FSM: states, opcodes,
// mux-select codes and the decoded instruction class.
package mc_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECI    = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_JAL      = 4'd9;
    localparam logic [3:0] S_JALR     = 4'd10;
    localparam logic [3:0] S_TRAP     = 4'd11;

    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_ALUI   = 7'd19;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JALR   = 7'd103;
    localparam logic [6:0] OP_JAL    = 7'd111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RS1   = 2'd2;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_MEM    = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;

    localparam logic [1:0] IMM_NONE = 2'd0;
    localparam logic [1:0] IMM_SEXT = 2'd1;

    typedef enum logic [2:0] {
        IC_LOAD    = 3'd0,
        IC_STORE   = 3'd1,
        IC_ALUI    = 3'd2,
        IC_BRANCH  = 3'd3,
        IC_JAL     = 3'd4,
        IC_JALR    = 3'd5,
        IC_ILLEGAL = 3'd6
    } instr_class_t;

endpackage

// File: rtl/mc_instr_class.sv
// Combinational opcode/funct3 classifier; anything outside the supported
// subset (including a bad funct3 on a known opcode) becomes IC_ILLEGAL.
module mc_instr_class
    import mc_pkg::*;
(
    input  logic [6:0]   i_opcode,
    input  logic [2:0]   i_funct3,
    output instr_class_t o_class
);

    always_comb begin
        o_class = IC_ILLEGAL;
        case (i_opcode)
            OP_LOAD:   if (i_funct3 == 3'b000 || i_funct3 == 3'b010 || i_funct3 == 3'b100) o_class = IC_LOAD;
            OP_STORE:  if (i_funct3 == 3'b000 || i_funct3 == 3'b010) o_class = IC_STORE;
            OP_ALUI:   if (i_funct3 == 3'b000) o_class = IC_ALUI;
            OP_BRANCH: if (i_funct3 == 3'b000 || i_funct3 == 3'b001) o_class = IC_BRANCH;
            OP_JAL:    o_class = IC_JAL;
            OP_JALR:   if (i_funct3 == 3'b000) o_class = IC_JALR;
            default:   o_class = IC_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM for the RV32I subset core; every output is forced
// low combinationally while rst_n is low so a reset aborts without side effects.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int D_WIDTH = 32
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [D_WIDTH-1:0] instr,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               adr_src,
    output logic               ir_write,
    output logic               pc_write,
    output logic               reg_write,
    output logic [1:0]         ImmSrc,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_ctrl,
    output logic [1:0]         result_src,
    output logic               instr_done,
    output logic               illegal
);

    logic [3:0]   r_state;
    logic [3:0]   w_next;
    logic         r_jalr_sub;
    logic         r_illegal;
    instr_class_t w_class;
    logic         w_unused_bits;

    logic       w_mem_req, w_mem_we, w_adr_src, w_ir_write, w_pc_write;
    logic       w_reg_write, w_instr_done;
    logic [1:0] w_imm_src, w_src_a, w_src_b, w_result_src;
    logic [2:0] w_alu_ctrl;

    assign w_unused_bits = ^{instr[D_WIDTH-1:15], instr[11:7]};

    mc_instr_class u_class (
        .i_opcode (instr[6:0]),
        .i_funct3 (instr[14:12]),
        .o_class  (w_class)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_jalr_sub <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_jalr_sub <= (r_state == S_JALR) && !r_jalr_sub;
            if (w_next == S_TRAP) r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (w_class)
                    IC_LOAD, IC_STORE: w_next = S_MEMADR;
                    IC_ALUI:           w_next = S_EXECI;
                    IC_BRANCH:         w_next = S_BRANCH;
                    IC_JAL:            w_next = S_JAL;
                    IC_JALR:           w_next = S_JALR;
                    default:           w_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                if (w_class == IC_LOAD)       w_next = S_MEMREAD;
                else if (w_class == IC_STORE) w_next = S_MEMWRITE;
                else                          w_next = S_TRAP;
            end
            S_MEMREAD:  if (mem_ready) w_next = S_MEMWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: if (mem_ready) w_next = S_FETCH;
            S_EXECI:    w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            S_JAL:      w_next = S_ALUWB;
            S_JALR:     w_next = r_jalr_sub ? S_ALUWB : S_JALR;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_adr_src    = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_instr_done = 1'b0;
        w_imm_src    = IMM_NONE;
        w_src_a      = SRCA_PC;
        w_src_b      = SRCB_RS2;
        w_alu_ctrl   = ALU_ADD;
        w_result_src = RES_ALUOUT;
        case (r_state)
            S_FETCH: begin
                w_mem_req    = 1'b1;
                w_src_b      = SRCB_FOUR;
                w_result_src = RES_ALU;
                w_ir_write   = mem_ready;
                w_pc_write   = mem_ready;
            end
            S_DECODE: begin
                w_src_a   = SRCA_OLDPC;
                w_src_b   = SRCB_IMM;
                w_imm_src = IMM_SEXT;
            end
            S_MEMADR, S_EXECI: begin
                w_src_a   = SRCA_RS1;
                w_src_b   = SRCB_IMM;
                w_imm_src = IMM_SEXT;
            end
            S_MEMREAD: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b1;
            end
            S_MEMWB: begin
                w_result_src = RES_MEM;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                w_mem_req    = 1'b1;
                w_mem_we     = 1'b1;
                w_adr_src    = 1'b1;
                w_instr_done = mem_ready;
            end
            S_ALUWB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            S_BRANCH: begin
                w_src_a      = SRCA_RS1;
                w_alu_ctrl   = ALU_SUB;
                w_pc_write   = instr[12] ? ~zero : zero;
                w_instr_done = 1'b1;
            end
            S_JAL: begin
                w_pc_write = 1'b1;
                w_src_a    = SRCA_OLDPC;
                w_src_b    = SRCB_FOUR;
            end
            S_JALR: begin
                // First pass forms rs1+imm in ALUOut; second redirects PC and forms the link.
                if (!r_jalr_sub) begin
                    w_src_a   = SRCA_RS1;
                    w_src_b   = SRCB_IMM;
                    w_imm_src = IMM_SEXT;
                end else begin
                    w_pc_write = 1'b1;
                    w_src_a    = SRCA_OLDPC;
                    w_src_b    = SRCB_FOUR;
                end
            end
            default: ;
        endcase
    end

    assign mem_req    = rst_n & w_mem_req;
    assign mem_we     = rst_n & w_mem_we;
    assign adr_src    = rst_n & w_adr_src;
    assign ir_write   = rst_n & w_ir_write;
    assign pc_write   = rst_n & w_pc_write;
    assign reg_write  = rst_n & w_reg_write;
    assign instr_done = rst_n & w_instr_done;
    assign ImmSrc     = {2{rst_n}} & w_imm_src;
    assign alu_src_a  = {2{rst_n}} & w_src_a;
    assign alu_src_b  = {2{rst_n}} & w_src_b;
    assign alu_ctrl   = {3{rst_n}} & w_alu_ctrl;
    assign result_src = {2{rst_n}} & w_result_src;
    assign illegal    = r_illegal;

endmodule
